// File: rtl/seq_ripple_borrow_subtractor_pkg.sv
// Shared types and default sizing for the sequential ripple-borrow subtractor.
// The FSM state encoding and the chunk index width derivation live here.
package seq_ripple_borrow_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH      = 64;
  localparam int DEF_CHUNK_W    = 8;
  localparam int DEF_NUM_CHUNKS = DEF_WIDTH / DEF_CHUNK_W;

  // A single-chunk configuration still needs a one-bit index register.
  function automatic int idx_width(input int num_chunks);
    return (num_chunks > 1) ? $clog2(num_chunks) : 1;
  endfunction

  localparam int DEF_IDX_W = idx_width(DEF_NUM_CHUNKS);

endpackage

// File: rtl/seq_ripple_borrow_subtractor_if.sv
// Operand/result handshake bundle for the sequential subtractor.
// SEQ_SUB_FLAGS_EN adds the borrow_o/zero_o status flags.
interface seq_ripple_borrow_subtractor_if
  import seq_ripple_borrow_subtractor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] num1_i;
  logic [WIDTH-1:0] num2_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] diff_o;
`ifdef SEQ_SUB_FLAGS_EN
  logic             borrow_o;
  logic             zero_o;
`endif

  modport master (
    output valid_i, num1_i, num2_i, ready_i,
`ifdef SEQ_SUB_FLAGS_EN
    input  borrow_o, zero_o,
`endif
    input  ready_o, valid_o, diff_o
  );

  modport slave (
    input  valid_i, num1_i, num2_i, ready_i,
`ifdef SEQ_SUB_FLAGS_EN
    output borrow_o, zero_o,
`endif
    output ready_o, valid_o, diff_o
  );

endinterface

// File: rtl/seq_ripple_borrow_subtractor_borrow_chunk_sub.sv
// Combinational CHUNK_W-bit ripple-borrow slice: diff = a - b - borrow_in.
module seq_ripple_borrow_subtractor_borrow_chunk_sub #(
  parameter int CHUNK_W = 8
) (
  input  logic [CHUNK_W-1:0] a_i,
  input  logic [CHUNK_W-1:0] b_i,
  input  logic               borrow_i,
  output logic [CHUNK_W-1:0] diff_o,
  output logic               borrow_o
);

  // Borrow ripples from LSB to MSB; a bit borrows when a < b + incoming borrow.
  always_comb begin
    logic w_bw;
    w_bw   = borrow_i;
    diff_o = '0;
    for (int i = 0; i < CHUNK_W; i++) begin
      diff_o[i] = a_i[i] ^ b_i[i] ^ w_bw;
      w_bw      = (~a_i[i] & b_i[i]) | (~(a_i[i] ^ b_i[i]) & w_bw);
    end
    borrow_o = w_bw;
  end

endmodule

// File: rtl/seq_ripple_borrow_subtractor.sv
// Multi-cycle subtractor: diff = num1 - num2 mod 2^WIDTH, one CHUNK_W slice per clock.
// Define SEQ_SUB_FLAGS_EN to expose the final borrow and zero-result flags.
module seq_ripple_borrow_subtractor
  import seq_ripple_borrow_subtractor_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int CHUNK_W = DEF_CHUNK_W
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  seq_ripple_borrow_subtractor_if.slave   bus
);

  localparam int               NUM_CHUNKS = WIDTH / CHUNK_W;
  localparam int               IDX_W      = idx_width(NUM_CHUNKS);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_CHUNKS - 1);
  localparam logic [WIDTH-1:0] LOW_MASK   = {WIDTH{1'b1}} >> CHUNK_W;

  state_t             r_state;
  logic               r_ready;
  logic               r_valid;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_diff;
  logic               r_borrow;
  logic [IDX_W-1:0]   r_idx;
`ifdef SEQ_SUB_FLAGS_EN
  logic               r_borrow_flag;
  logic               r_zero_flag;
`endif

  logic [CHUNK_W-1:0] w_a_chunk;
  logic [CHUNK_W-1:0] w_b_chunk;
  logic [CHUNK_W-1:0] w_d_chunk;
  logic               w_borrow_out;

  assign w_a_chunk = r_a[int'(r_idx) * CHUNK_W +: CHUNK_W];
  assign w_b_chunk = r_b[int'(r_idx) * CHUNK_W +: CHUNK_W];

  seq_ripple_borrow_subtractor_borrow_chunk_sub #(
    .CHUNK_W (CHUNK_W)
  ) u_chunk (
    .a_i      (w_a_chunk),
    .b_i      (w_b_chunk),
    .borrow_i (r_borrow),
    .diff_o   (w_d_chunk),
    .borrow_o (w_borrow_out)
  );

  // On the last chunk all lower slices are already in r_diff, so the zero
  // flag only needs those plus the slice being written this cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state       <= IDLE;
      r_ready       <= 1'b1;
      r_valid       <= 1'b0;
      r_a           <= '0;
      r_b           <= '0;
      r_diff        <= '0;
      r_borrow      <= 1'b0;
      r_idx         <= '0;
`ifdef SEQ_SUB_FLAGS_EN
      r_borrow_flag <= 1'b0;
      r_zero_flag   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.valid_i && r_ready) begin
            r_a           <= bus.num1_i;
            r_b           <= bus.num2_i;
            r_idx         <= '0;
            r_borrow      <= 1'b0;
            r_ready       <= 1'b0;
            r_state       <= RUN;
`ifdef SEQ_SUB_FLAGS_EN
            r_borrow_flag <= 1'b0;
            r_zero_flag   <= 1'b0;
`endif
          end
        end
        RUN: begin
          r_diff[int'(r_idx) * CHUNK_W +: CHUNK_W] <= w_d_chunk;
          r_borrow <= w_borrow_out;
          if (r_idx == LAST_IDX) begin
            r_idx         <= '0;
            r_valid       <= 1'b1;
            r_state       <= DONE;
`ifdef SEQ_SUB_FLAGS_EN
            r_borrow_flag <= w_borrow_out;
            r_zero_flag   <= ((r_diff & LOW_MASK) == '0) && (w_d_chunk == '0);
`endif
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        DONE: begin
          if (bus.ready_i) begin
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready_o  = r_ready;
  assign bus.valid_o  = r_valid;
  assign bus.diff_o   = r_diff;
`ifdef SEQ_SUB_FLAGS_EN
  assign bus.borrow_o = r_borrow_flag;
  assign bus.zero_o   = r_zero_flag;
`endif

endmodule
